booth_operand_sequencer: RTL and testbench

BOOTH_OPERAND_SEQUENCER -- requirements
Module: booth_operand_sequencer

---
 rtl/booth_operand_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_booth_operand_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_operand_sequencer.sv
// Operand sequencer and result checker for a downstream 8x8 signed Booth multiplier.
// Runs a campaign of directed then LFSR-generated operand pairs and tallies pass/fail.
module booth_operand_sequencer #(
   parameter int          NUM_VECTORS    = 260,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] product,
   input  logic        done,
   output logic [7:0]  multiplicand,
   output logic [7:0]  multiplier,
   output logic        start,
   output logic        busy,
   output logic        finished,
   output logic [15:0] pass_count,
   output logic [15:0] fail_count,
   output logic        timeout_err,
   output logic [7:0]  last_fail_a,
   output logic [7:0]  last_fail_b
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] VEC_LIMIT    = 17'(NUM_VECTORS);

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic        run_q;
   logic        run_edge;
   logic [15:0] index;
   logic [15:0] lfsr;
   logic [15:0] product_cap;
   logic [31:0] wait_cnt;
   logic [15:0] expected;
   logic        last_vector;
   logic        timeout_hit;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      if (v[0]) begin
         lfsr_step = (v >> 1) ^ 16'hB400;
      end else begin
         lfsr_step = v >> 1;
      end
   endfunction

   // {A, B} for a vector: four corner cases first, then straight from the LFSR
   function automatic logic [15:0] operands_for(input logic [15:0] idx, input logic [15:0] l);
      case (idx)
         16'd0:   operands_for = 16'h0000;
         16'd1:   operands_for = 16'h8080;
         16'd2:   operands_for = 16'h7F80;
         16'd3:   operands_for = 16'hFFFF;
         default: operands_for = l;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         sat_inc = v;
      end else begin
         sat_inc = v + 16'd1;
      end
   endfunction

   // Low 16 bits of the sign-extended product are the exact two's-complement result
   always_comb begin
      expected    = {{8{multiplicand[7]}}, multiplicand} * {{8{multiplier[7]}}, multiplier};
      run_edge    = run & ~run_q;
      last_vector = ({1'b0, index} + 17'd1) >= VEC_LIMIT;
      timeout_hit = !done && (wait_cnt >= TIMEOUT_LAST);
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_FINISH: begin
            if (run_edge) begin
               state_next = S_LOAD;
            end else begin
               state_next = state;
            end
         end
         S_LOAD:  state_next = S_START;
         S_START: state_next = S_WAIT;
         S_WAIT: begin
            if (done) begin
               state_next = S_CHECK;
            end else if (timeout_hit) begin
               state_next = S_FINISH;
            end else begin
               state_next = S_WAIT;
            end
         end
         S_CHECK: begin
            if (last_vector) begin
               state_next = S_FINISH;
            end else begin
               state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (!done) begin
               state_next = S_LOAD;
            end else begin
               state_next = S_GAP;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Status flags are derived from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         run_q        <= 1'b0;
         index        <= 16'd0;
         lfsr         <= LFSR_SEED;
         wait_cnt     <= 32'd0;
         product_cap  <= 16'd0;
         multiplicand <= 8'd0;
         multiplier   <= 8'd0;
         start        <= 1'b0;
         busy         <= 1'b0;
         finished     <= 1'b0;
         pass_count   <= 16'd0;
         fail_count   <= 16'd0;
         timeout_err  <= 1'b0;
         last_fail_a  <= 8'd0;
         last_fail_b  <= 8'd0;
      end else begin
         state    <= state_next;
         run_q    <= run;
         start    <= (state_next == S_START);
         busy     <= (state_next == S_LOAD) || (state_next == S_START) || (state_next == S_WAIT) ||
                     (state_next == S_CHECK) || (state_next == S_GAP);
         finished <= (state_next == S_FINISH);
         case (state)
            S_IDLE, S_FINISH: begin
               if (run_edge) begin
                  index                      <= 16'd0;
                  lfsr                       <= LFSR_SEED;
                  pass_count                 <= 16'd0;
                  fail_count                 <= 16'd0;
                  timeout_err                <= 1'b0;
                  last_fail_a                <= 8'd0;
                  last_fail_b                <= 8'd0;
                  {multiplicand, multiplier} <= operands_for(16'd0, LFSR_SEED);
               end
            end
            S_GAP: begin
               // index and lfsr already point at the next vector here
               if (!done) begin
                  {multiplicand, multiplier} <= operands_for(index, lfsr);
               end
            end
            S_START: wait_cnt <= 32'd1;
            S_WAIT: begin
               if (done) begin
                  product_cap <= product;
               end else if (timeout_hit) begin
                  timeout_err <= 1'b1;
                  fail_count  <= sat_inc(fail_count);
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            S_CHECK: begin
               if (product_cap == expected) begin
                  pass_count <= sat_inc(pass_count);
               end else begin
                  fail_count  <= sat_inc(fail_count);
                  last_fail_a <= multiplicand;
                  last_fail_b <= multiplier;
               end
               index <= index + 16'd1;
               lfsr  <= lfsr_step(lfsr);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Scoreboard bench: instance 0 runs 4-vector campaigns, instance 1 the full 260-vector campaign.
module tb_booth_operand_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_v      [2];
   logic [15:0] product_v  [2];
   logic        done_v     [2];
   logic [7:0]  mcand_v    [2];
   logic [7:0]  mplier_v   [2];
   logic        start_v    [2];
   logic        busy_v     [2];
   logic        fin_v      [2];
   logic [15:0] pass_v     [2];
   logic [15:0] fail_v     [2];
   logic        tmo_v      [2];
   logic [7:0]  lfa_v      [2];
   logic [7:0]  lfb_v      [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int sel = 0;
   int lat = 1;
   int hold = 1;
   int fault_idx = -1;
   int never_done = 0;
   int mdl_idx = 0;
   logic        prev_start [2];
   logic [15:0] exp_q [$];
   logic [15:0] dir_ops  [4];
   logic [15:0] dir_prod [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      booth_operand_sequencer #(
         .NUM_VECTORS   ((g == 0) ? 4 : 260),
         .TIMEOUT_CYCLES(64),
         .LFSR_SEED     (16'hACE1)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .run         (run_v[g]),
         .product     (product_v[g]),
         .done        (done_v[g]),
         .multiplicand(mcand_v[g]),
         .multiplier  (mplier_v[g]),
         .start       (start_v[g]),
         .busy        (busy_v[g]),
         .finished    (fin_v[g]),
         .pass_count  (pass_v[g]),
         .fail_count  (fail_v[g]),
         .timeout_err (tmo_v[g]),
         .last_fail_a (lfa_v[g]),
         .last_fail_b (lfb_v[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic push_ops(input int count);
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < count; i++) begin
         if (i < 4) exp_q.push_back(dir_ops[i]);
         else exp_q.push_back(l);
         l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
   endtask

   task automatic start_campaign(input int g);
      @(negedge clk) run_v[g] = 1'b0;
      @(negedge clk) run_v[g] = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_finished(input int g, input int limit, input string name);
      int n;
      n = 0;
      while (!fin_v[g] && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!fin_v[g]) begin
         errors++;
         $display("FAIL %s: finished not seen within %0d cycles", name, limit);
      end
   endtask

   task automatic chk_zero(input int g, input string name);
      chk({name, "_flags"}, {28'd0, start_v[g], busy_v[g], fin_v[g], tmo_v[g]}, 32'd0);
      chk({name, "_counts"}, {pass_v[g], fail_v[g]}, 32'd0);
      chk({name, "_operands"}, {lfa_v[g], lfb_v[g], mcand_v[g], mplier_v[g]}, 32'd0);
   endtask

   // Behavioural multiplier: answers the selected instance after lat cycles, holds done for hold cycles
   initial begin
      logic [7:0]  a, b;
      logic [15:0] p;
      byte         sa, sb;
      int          ip;
      for (int g = 0; g < 2; g++) begin
         done_v[g]    = 1'b0;
         product_v[g] = 16'h0000;
      end
      forever begin
         @(negedge clk);
         if (start_v[sel] && never_done == 0) begin
            a = mcand_v[sel];
            b = mplier_v[sel];
            if (sel == 0 && mdl_idx < 4) begin
               p = dir_prod[mdl_idx];
            end else begin
               sa = a;
               sb = b;
               ip = sa * sb;
               p  = ip[15:0];
            end
            if (mdl_idx == fault_idx) p = p ^ 16'h0001;
            mdl_idx++;
            repeat (lat) @(negedge clk);
            product_v[sel] = p;
            done_v[sel]    = 1'b1;
            repeat (hold) @(negedge clk);
            done_v[sel]    = 1'b0;
            product_v[sel] = 16'hDEAD;
         end
      end
   end

   // Monitor: every start pops the scoreboard and checks operands and handshake rules
   initial begin
      logic [15:0] e;
      prev_start[0] = 1'b0;
      prev_start[1] = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            if (start_v[g]) begin
               start_cyc = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_start: dut%0d issued start with operands 0x%0h%0h, none expected",
                           g, mcand_v[g], mplier_v[g]);
               end else begin
                  e = exp_q.pop_front();
                  chk("operands", {16'd0, mcand_v[g], mplier_v[g]}, {16'd0, e});
               end
               chk("start_while_done", {31'd0, done_v[g]}, 32'd0);
               chk("start_width", {31'd0, prev_start[g]}, 32'd0);
            end
            prev_start[g] = start_v[g];
         end
      end
   end

   initial begin
      int elapsed;
      dir_ops[0]  = 16'h0000;  dir_ops[1]  = 16'h8080;
      dir_ops[2]  = 16'h7F80;  dir_ops[3]  = 16'hFFFF;
      dir_prod[0] = 16'h0000;  dir_prod[1] = 16'h4000;
      dir_prod[2] = 16'hC080;  dir_prod[3] = 16'h0001;
      rst = 1'b1;
      run_v[0] = 1'b0;
      run_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero(0, "reset0");
      chk_zero(1, "reset1");
      rst = 1'b0;

      // Directed 4-vector campaign with a correct multiplier
      mdl_idx = 0;
      push_ops(4);
      start_campaign(0);
      chk("dir_busy", {31'd0, busy_v[0]}, 32'd1);
      wait_finished(0, 200, "dir_finish");
      chk("dir_pass", {16'd0, pass_v[0]}, 32'd4);
      chk("dir_fail", {16'd0, fail_v[0]}, 32'd0);
      chk("dir_flags", {29'd0, busy_v[0], fin_v[0], tmo_v[0]}, 32'b010);
      chk("dir_queue", exp_q.size(), 32'd0);

      // Rerun from FINISH with a corrupted product on vector 2
      mdl_idx = 0;
      fault_idx = 2;
      push_ops(4);
      start_campaign(0);
      chk("rerun_cleared", {pass_v[0], fail_v[0]}, 32'd0);
      wait_finished(0, 200, "fault_finish");
      chk("fault_pass", {16'd0, pass_v[0]}, 32'd3);
      chk("fault_fail", {16'd0, fail_v[0]}, 32'd1);
      chk("fault_last_ab", {16'd0, lfa_v[0], lfb_v[0]}, 32'h7F80);
      chk("fault_queue", exp_q.size(), 32'd0);
      fault_idx = -1;

      // Multiplier never answers: abort exactly TIMEOUT_CYCLES after start
      never_done = 1;
      push_ops(1);
      start_campaign(0);
      elapsed = 0;
      while (!tmo_v[0] && elapsed < 200) begin
         @(negedge clk);
         elapsed++;
      end
      chk("timeout_seen", {31'd0, tmo_v[0]}, 32'd1);
      chk("timeout_latency", cyc - start_cyc, 32'd64);
      chk("timeout_fail", {16'd0, fail_v[0]}, 32'd1);
      chk("timeout_pass", {16'd0, pass_v[0]}, 32'd0);
      chk("timeout_finished", {31'd0, fin_v[0]}, 32'd1);
      repeat (5) @(negedge clk);
      chk("finish_hold", {15'd0, fin_v[0], fail_v[0]}, 32'h0001_0001);

      // Reset while stuck in WAIT
      push_ops(1);
      start_campaign(0);
      chk("rerun_tmo_clear", {31'd0, tmo_v[0]}, 32'd0);
      repeat (6) @(negedge clk);
      chk("pre_reset_busy", {31'd0, busy_v[0]}, 32'd1);
      rst = 1'b1;
      run_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero(0, "midwait_reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", {30'd0, busy_v[0], fin_v[0]}, 32'd0);
      never_done = 0;

      // Full campaign on instance 1 with done held for three cycles
      sel = 1;
      lat = 2;
      hold = 3;
      mdl_idx = 0;
      push_ops(260);
      start_campaign(1);
      wait_finished(1, 6000, "held_finish");
      chk("held_pass", {16'd0, pass_v[1]}, 32'd260);
      chk("held_fail", {16'd0, fail_v[1]}, 32'd0);
      chk("held_tmo", {31'd0, tmo_v[1]}, 32'd0);
      chk("held_queue", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
